// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: access sizes,
// FSM encoding and the control values that turn a MEM/WB load into a bubble.
package mem_access_stage_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  localparam logic BUBBLE_REGWRITE   = 1'b0;
  localparam logic BUBBLE_FPREGWRITE = 1'b0;
  localparam logic BUBBLE_MUL        = 1'b0;

  // Big-endian numbering: bits [30:31] are the byte offset within the word.
  function automatic logic [0:31] word_addr(input logic [0:31] addr);
    return {addr[0:29], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// dmem_req is held with all request fields stable until the cycle in which
// dmem_ready is high; dmem_rdata is valid in that same cycle.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [0:31] dmem_addr;
  logic [0:3]  dmem_byteEn;
  logic [0:31] dmem_wdata;
  logic        dmem_ready;
  logic [0:31] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_byteEn, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_byteEn, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_store_align.sv
// Store lane formation and misalignment detection from the low address bits
// and the access size (lane 0 = bits [0:7]).
module mem_access_stage_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [0:1]  addr_lo_i,
  input  logic [0:1]  dsize_i,
  input  logic [0:31] store_data_i,
  output logic [0:3]  byte_en_o,
  output logic [0:31] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    byte_en_o  = 4'b1111;
    wdata_o    = store_data_i;
    misalign_o = 1'b0;
    case (dsize_i)
      DSIZE_BYTE: begin
        byte_en_o = 4'b1000 >> addr_lo_i;
        wdata_o   = {4{store_data_i[24:31]}};
      end
      DSIZE_HALF: begin
        byte_en_o  = 4'b1100 >> addr_lo_i;
        wdata_o    = {2{store_data_i[16:31]}};
        misalign_o = addr_lo_i[1];
      end
      default: misalign_o = |addr_lo_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory accesses with a req/ready handshake,
// stalls upstream while one is outstanding, and registers the MEM/WB latch.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [0:31] nextPC_in,
  input  logic [0:31] aluResult_in,
  input  logic [0:31] storeData_in,
  input  logic [0:4]  destReg_in,
  input  logic [0:4]  fDestReg_in,
  input  logic [0:63] fbusW_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        PCtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        loadSign_in,
  input  logic        FPRegWrite_in,
  input  logic        mul_in,
  input  logic [0:1]  DSize_in,
  mem_access_stage_if.master dmem,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_error_out,
  output logic [0:31] nextPC_out,
  output logic [0:31] aluResult_out,
  output logic [0:31] dataOut_out,
  output logic [0:4]  destReg_out,
  output logic [0:4]  fDestReg_out,
  output logic [0:63] fbusW_out,
  output logic        PCtoReg_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        loadSign_out,
  output logic        FPRegWrite_out,
  output logic        mul_out,
  output logic [0:1]  DSize_out,
  output state_e      state_dbg_o
);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               req_q, req_d, we_q, we_d;
  logic [0:31]        addr_q, addr_d, wdata_q, wdata_d;
  logic [0:3]         ben_q, ben_d;
  logic               misalign_d, bus_error_d;
  logic               load_wb, bubble_wb, capture_rdata, stall;
  logic [0:3]         sa_ben;
  logic [0:31]        sa_wdata;
  logic               sa_misalign;
  logic               mem_op;

  mem_access_stage_store_align u_store_align (
    .addr_lo_i    (aluResult_in[30:31]),
    .dsize_i      (DSize_in),
    .store_data_i (storeData_in),
    .byte_en_o    (sa_ben),
    .wdata_o      (sa_wdata),
    .misalign_o   (sa_misalign)
  );

  assign mem_op = valid_in & (MemRead_in | MemWrite_in);

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    ben_d         = ben_q;
    wdata_d       = wdata_q;
    misalign_d    = 1'b0;
    bus_error_d   = 1'b0;
    load_wb       = 1'b0;
    bubble_wb     = 1'b0;
    capture_rdata = 1'b0;
    stall         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && sa_misalign) begin
          misalign_d = 1'b1;
          bubble_wb  = 1'b1;
        end else if (mem_op) begin
          req_d     = 1'b1;
          we_d      = MemWrite_in;
          addr_d    = word_addr(aluResult_in);
          ben_d     = sa_ben;
          wdata_d   = sa_wdata;
          tmo_d     = '0;
          state_d   = S_ACCESS;
          stall     = 1'b1;
          bubble_wb = 1'b1;
        end else if (valid_in) begin
          load_wb = 1'b1;
        end else begin
          bubble_wb = 1'b1;
        end
      end
      S_ACCESS: begin
        // Ready takes priority over an expiring timeout in the same cycle.
        if (dmem.dmem_ready) begin
          load_wb       = 1'b1;
          capture_rdata = ~we_q;
          req_d         = 1'b0;
          state_d       = S_IDLE;
        end else if (tmo_q == TMO_W'(MEM_TIMEOUT)) begin
          bus_error_d = 1'b1;
          bubble_wb   = 1'b1;
          req_d       = 1'b0;
          state_d     = S_IDLE;
        end else begin
          tmo_d     = tmo_q + TMO_W'(1);
          stall     = 1'b1;
          bubble_wb = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      ben_q         <= '0;
      wdata_q       <= '0;
      misalign_out  <= 1'b0;
      bus_error_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      ben_q         <= ben_d;
      wdata_q       <= wdata_d;
      misalign_out  <= misalign_d;
      bus_error_out <= bus_error_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nextPC_out     <= '0;
      aluResult_out  <= '0;
      dataOut_out    <= '0;
      destReg_out    <= '0;
      fDestReg_out   <= '0;
      fbusW_out      <= '0;
      PCtoReg_out    <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemToReg_out   <= 1'b0;
      loadSign_out   <= 1'b0;
      FPRegWrite_out <= 1'b0;
      mul_out        <= 1'b0;
      DSize_out      <= '0;
    end else if (load_wb) begin
      nextPC_out     <= nextPC_in;
      aluResult_out  <= aluResult_in;
      destReg_out    <= destReg_in;
      fDestReg_out   <= fDestReg_in;
      fbusW_out      <= fbusW_in;
      PCtoReg_out    <= PCtoReg_in;
      RegWrite_out   <= RegWrite_in;
      MemToReg_out   <= MemToReg_in;
      loadSign_out   <= loadSign_in;
      FPRegWrite_out <= FPRegWrite_in;
      mul_out        <= mul_in;
      DSize_out      <= DSize_in;
      if (capture_rdata) dataOut_out <= dmem.dmem_rdata;
    end else if (bubble_wb) begin
      RegWrite_out   <= BUBBLE_REGWRITE;
      FPRegWrite_out <= BUBBLE_FPREGWRITE;
      mul_out        <= BUBBLE_MUL;
    end
  end

  // Stall is combinational from state, so it is forced low while in reset.
  assign stall_out        = stall & ~reset;
  assign dmem.dmem_req    = req_q;
  assign dmem.dmem_we     = we_q;
  assign dmem.dmem_addr   = addr_q;
  assign dmem.dmem_byteEn = ben_q;
  assign dmem.dmem_wdata  = wdata_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a driver issues ops and pushes expected
// bus requests, write-backs and exceptions; a monitor pops and compares them.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        valid_in, MemRead_in, MemWrite_in, PCtoReg_in, RegWrite_in;
  logic        MemToReg_in, loadSign_in, FPRegWrite_in, mul_in;
  logic [31:0] nextPC_in, aluResult_in, storeData_in;
  logic [4:0]  destReg_in, fDestReg_in;
  logic [63:0] fbusW_in;
  logic [1:0]  DSize_in;
  logic        stall_out, misalign_out, bus_error_out;
  logic [31:0] nextPC_out, aluResult_out, dataOut_out;
  logic [4:0]  destReg_out, fDestReg_out;
  logic [63:0] fbusW_out;
  logic        PCtoReg_out, RegWrite_out, MemToReg_out, loadSign_out;
  logic        FPRegWrite_out, mul_out;
  logic [1:0]  DSize_out;
  state_e      state_dbg_o;

  mem_access_stage_if mif ();

  mem_access_stage #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in),
    .nextPC_in(nextPC_in), .aluResult_in(aluResult_in), .storeData_in(storeData_in),
    .destReg_in(destReg_in), .fDestReg_in(fDestReg_in), .fbusW_in(fbusW_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .PCtoReg_in(PCtoReg_in),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .loadSign_in(loadSign_in),
    .FPRegWrite_in(FPRegWrite_in), .mul_in(mul_in), .DSize_in(DSize_in),
    .dmem(mif.master),
    .stall_out(stall_out), .misalign_out(misalign_out), .bus_error_out(bus_error_out),
    .nextPC_out(nextPC_out), .aluResult_out(aluResult_out), .dataOut_out(dataOut_out),
    .destReg_out(destReg_out), .fDestReg_out(fDestReg_out), .fbusW_out(fbusW_out),
    .PCtoReg_out(PCtoReg_out), .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .loadSign_out(loadSign_out), .FPRegWrite_out(FPRegWrite_out), .mul_out(mul_out),
    .DSize_out(DSize_out), .state_dbg_o(state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [68:0] req_q[$];  // {we, addr, byteEn, wdata}
  logic [68:0] wb_q[$];   // {aluResult, dataOut, destReg}
  logic [1:0]  exc_q[$];  // 1 = misalign, 2 = bus error

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_delay = 1;  // ready on this ACCESS cycle; 0 = never
  logic [31:0] mem_rdata_val = '0;
  int          acc_cycles = 0;

  initial begin
    mif.dmem_ready = 1'b0;
    mif.dmem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      mif.dmem_ready = 1'b0;
      if (mif.dmem_req) begin
        acc_cycles++;
        if (acc_cycles == mem_delay) begin
          mif.dmem_ready = 1'b1;
          mif.dmem_rdata = mem_rdata_val;
        end
      end else begin
        acc_cycles = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic req_prev = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (mif.dmem_req && !req_prev) begin
        if (req_q.size() == 0) check("unexpected_req", 128'(1), 128'(0));
        else check("dmem_request", 128'({mif.dmem_we, mif.dmem_addr, mif.dmem_byteEn,
                                           mif.dmem_wdata}), 128'(req_q.pop_front()));
      end
      req_prev = mif.dmem_req;
      if (RegWrite_out) begin
        if (wb_q.size() == 0) check("unexpected_wb", 128'(1), 128'(0));
        else check("mem_wb", 128'({aluResult_out, dataOut_out, destReg_out}),
                   128'(wb_q.pop_front()));
      end
      if (misalign_out) begin
        if (exc_q.size() == 0) check("unexpected_misalign", 128'(1), 128'(0));
        else check("misalign_exc", 128'(2'd1), 128'(exc_q.pop_front()));
      end
      if (bus_error_out) begin
        if (exc_q.size() == 0) check("unexpected_bus_error", 128'(1), 128'(0));
        else check("bus_error_exc", 128'(2'd2), 128'(exc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0;
    PCtoReg_in = 1'b0; MemToReg_in = 1'b0; loadSign_in = 1'b0; FPRegWrite_in = 1'b0;
    mul_in = 1'b0; DSize_in = 2'b10; nextPC_in = '0; aluResult_in = '0;
    storeData_in = '0; destReg_in = '0; fDestReg_in = '0; fbusW_in = '0;
  endtask

  // Called just after a rising edge; returns just after a rising edge with
  // one idle cycle inserted so the next op starts from a bubble.
  task automatic run_op(input string name, input logic rd, input logic wr, input logic rw,
                        input logic [1:0] ds, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] dest, input int delay,
                        input logic [31:0] rdata, input int exp_stalls);
    int stalls = 0;
    int rw_hi  = 0;
    mem_delay = delay; mem_rdata_val = rdata;
    valid_in = 1'b1; MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw;
    DSize_in = ds; aluResult_in = addr; storeData_in = sdata; destReg_in = dest;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!stall_out) break;
      stalls++;
      if (RegWrite_out) rw_hi++;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    drive_idle();
    @(posedge clock); #1;
    check({name, "_stall_cycles"}, 128'(stalls), 128'(exp_stalls));
    check({name, "_regwrite_in_stall"}, 128'(rw_hi), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    repeat (3) @(posedge clock);
    #1;
    check("rst_req", 128'(mif.dmem_req), 128'(0));
    check("rst_state", 128'(state_dbg_o), 128'(S_IDLE));
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_bus", 128'({mif.dmem_we, mif.dmem_addr, mif.dmem_byteEn, mif.dmem_wdata}),
          128'(0));
    check("idle_outputs", 128'({aluResult_out, dataOut_out, RegWrite_out, misalign_out,
                                bus_error_out, stall_out}), 128'(0));

    // ALU op passes through in one cycle
    wb_q.push_back({32'h0000_1234, 32'h0, 5'd5});
    run_op("alu", 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_1234, 32'h0, 5'd5, 1, 32'h0, 0);

    // word load at 0x100, ready on the third ACCESS cycle
    req_q.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h1122_3344});
    wb_q.push_back({32'h0000_0100, 32'hDEAD_BEEF, 5'd7});
    run_op("ld_word", 1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0100, 32'h1122_3344, 5'd7, 3,
           32'hDEAD_BEEF, 3);

    // byte store 0xAB at 0x203
    req_q.push_back({1'b1, 32'h0000_0200, 4'b0001, 32'hABAB_ABAB});
    run_op("st_byte", 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0203, 32'h1234_56AB, 5'd0, 1,
           32'h0, 1);

    // half store 0x5566 at 0x102
    req_q.push_back({1'b1, 32'h0000_0100, 4'b0011, 32'h5566_5566});
    run_op("st_half", 1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'hFFFF_5566, 5'd0, 2,
           32'h0, 2);

    // misaligned half load: exception, no request, no write-back
    exc_q.push_back(2'd1);
    run_op("ld_half_mis", 1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0101, 32'h0, 5'd4, 1, 32'h0, 0);

    // byte load at 0x102
    req_q.push_back({1'b0, 32'h0000_0100, 4'b0010, 32'h0});
    wb_q.push_back({32'h0000_0102, 32'hCAFE_F00D, 5'd3});
    run_op("ld_byte", 1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0102, 32'h0, 5'd3, 1,
           32'hCAFE_F00D, 1);

    // misaligned word store
    exc_q.push_back(2'd1);
    run_op("st_word_mis", 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0202, 32'h0, 5'd0, 1, 32'h0, 0);

    // timeout: ready never comes, abort when counter reaches 4
    req_q.push_back({1'b0, 32'h0000_0300, 4'b1111, 32'h0});
    exc_q.push_back(2'd2);
    run_op("ld_timeout", 1'b1, 1'b0, 1'b1, 2'b11, 32'h0000_0300, 32'h0, 5'd2, 0, 32'h0, 5);
    check("tmo_state_idle", 128'(state_dbg_o), 128'(S_IDLE));
    check("tmo_req_dropped", 128'(mif.dmem_req), 128'(0));

    // ALU op after: dataOut still holds the last loaded word
    wb_q.push_back({32'hA5A5_0000, 32'hCAFE_F00D, 5'd9});
    run_op("alu2", 1'b0, 1'b0, 1'b1, 2'b10, 32'hA5A5_0000, 32'h0, 5'd9, 1, 32'h0, 0);

    // reset in the middle of an access
    req_q.push_back({1'b0, 32'h0000_0400, 4'b1111, 32'h0});
    mem_delay = 0;
    valid_in = 1'b1; MemRead_in = 1'b1; DSize_in = 2'b10; aluResult_in = 32'h0000_0400;
    @(posedge clock); #1;
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("midrst_req", 128'(mif.dmem_req), 128'(0));
    check("midrst_bus", 128'({mif.dmem_addr, mif.dmem_byteEn}), 128'(0));
    check("midrst_wb", 128'({aluResult_out, dataOut_out}), 128'(0));
    check("midrst_stall", 128'(stall_out), 128'(0));
    check("midrst_state", 128'(state_dbg_o), 128'(S_IDLE));
    drive_idle();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    wb_q.push_back({32'h0000_0077, 32'h0, 5'd1});
    run_op("alu_after_rst", 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0077, 32'h0, 5'd1, 1,
           32'h0, 0);

    repeat (2) @(posedge clock);
    #1;
    check("req_q_drained", 128'(req_q.size()), 128'(0));
    check("wb_q_drained", 128'(wb_q.size()), 128'(0));
    check("exc_q_drained", 128'(exc_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
